multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_iter_unit.sv | 110 +++++++++++
 rtl/multicycle_alu.sv | 129 ++++++++++++
 tb/tb_multicycle_alu.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multicycle ALU: opcode encodings and top-level FSM states.
// Optional multiplier is controlled by MULTICYCLE_ALU_MUL_EN (see multicycle_alu.sv).
package alu_pkg;

   typedef enum logic [2:0] {
      OP_FWD = 3'b000,
      OP_ADD = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_ROR = 3'b100,
      OP_MUL = 3'b101,
      OP_SRA = 3'b110,
      OP_SHL = 3'b111
   } alu_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } alu_state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: one rotate/shift bit or one multiplier bit per EXEC cycle.
// Loaded on the edge the top accepts a request; 'last' flags the final EXEC cycle and
// 'result' is the value the accumulator takes on that cycle's edge.
// The shift-add multiplier exists only when MULTICYCLE_ALU_MUL_EN is defined.
module alu_iter_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  alu_op_t          load_op,
   input  logic [WIDTH-1:0] load_a,
   input  logic [WIDTH-1:0] load_b,
   input  logic             step,
   output logic             last,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned SW = $clog2(WIDTH);
   localparam int unsigned CW = SW + 1;
   localparam logic [WIDTH-1:0] W_VEC = WIDTH'(WIDTH);
   localparam logic [CW-1:0]    W_CNT = CW'(WIDTH);

   alu_op_t          op_q;
   logic [WIDTH-1:0] acc_q;
   logic [CW-1:0]    count_q;
   logic             active_q;   // amount was non-zero; otherwise steps leave acc untouched
   logic             right_q;    // SHL direction, from the sign of DATA2
   logic [CW-1:0]    amt;
   logic [WIDTH-1:0] mag;
   logic [WIDTH-1:0] step_val;

`ifdef MULTICYCLE_ALU_MUL_EN
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
`endif

   // Decode the shift amount (cycle count) from the incoming request.
   always_comb begin
      mag = load_b[WIDTH-1] ? -load_b : load_b;
      amt = '0;
      case (load_op)
         OP_ROR: amt = CW'(load_b[SW-1:0]);
         OP_SRA: amt = (load_b >= W_VEC) ? W_CNT : CW'(load_b[SW-1:0]);
         OP_SHL: amt = (mag >= W_VEC) ? W_CNT : CW'(mag[SW-1:0]);
`ifdef MULTICYCLE_ALU_MUL_EN
         OP_MUL: amt = W_CNT;
`endif
         default: amt = '0;
      endcase
   end

   // One iteration of the selected operation applied to the accumulator.
   always_comb begin
      step_val = acc_q;
      if (active_q) begin
         case (op_q)
            OP_ROR: step_val = {acc_q[0], acc_q[WIDTH-1:1]};
            OP_SRA: step_val = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            OP_SHL: step_val = right_q ? {1'b0, acc_q[WIDTH-1:1]} : {acc_q[WIDTH-2:0], 1'b0};
`ifdef MULTICYCLE_ALU_MUL_EN
            OP_MUL: step_val = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif
            default: step_val = acc_q;
         endcase
      end
   end

   assign result = step_val;
   assign last   = (count_q == CW'(1));

   // Accumulator, counter and mode registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q     <= OP_FWD;
         acc_q    <= '0;
         count_q  <= '0;
         active_q <= 1'b0;
         right_q  <= 1'b0;
      end else if (load) begin
         op_q     <= load_op;
         acc_q    <= (load_op == OP_MUL) ? '0 : load_a;
         count_q  <= (amt == '0) ? CW'(1) : amt;
         active_q <= (amt != '0);
         right_q  <= load_b[WIDTH-1];
      end else if (step) begin
         acc_q    <= step_val;
         count_q  <= count_q - CW'(1);
      end
   end

`ifdef MULTICYCLE_ALU_MUL_EN
   // Multiplicand moves left and multiplier right, consuming one multiplier bit per step.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
      end else if (load) begin
         mcand_q  <= load_a;
         mplier_q <= load_b;
      end else if (step) begin
         mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
         mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
      end
   end
`endif

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU top: IDLE/EXEC FSM, operand latches and registered result/flags.
// Define MULTICYCLE_ALU_MUL_EN to build the shift-add multiplier; without it SELECT=101
// finishes in one cycle with RESULT=0.
module multicycle_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       select,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   alu_state_t       state_q, state_d;
   alu_op_t          sel_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             accept;
   logic             iter_last;
   logic [WIDTH-1:0] iter_result;
   logic [WIDTH-1:0] exec_result;

   alu_iter_unit #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (accept),
      .load_op (alu_op_t'(select)),
      .load_a  (data1),
      .load_b  (data2),
      .step    (state_q == EXEC),
      .last    (iter_last),
      .result  (iter_result)
   );

   // Select the value written to RESULT on the final EXEC cycle.
   always_comb begin
      exec_result = '0;
      case (sel_q)
         OP_FWD: exec_result = b_q;
         OP_ADD: exec_result = a_q + b_q;
         OP_AND: exec_result = a_q & b_q;
         OP_OR:  exec_result = a_q | b_q;
         OP_ROR: exec_result = iter_result;
         OP_SRA: exec_result = iter_result;
         OP_SHL: exec_result = iter_result;
`ifdef MULTICYCLE_ALU_MUL_EN
         OP_MUL: exec_result = iter_result;
`else
         OP_MUL: exec_result = '0;
`endif
      endcase
   end

   // Next-state and output logic; DONE is a one-cycle pulse on the finishing edge.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      accept   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = EXEC;
               busy_d  = 1'b1;
            end
         end
         EXEC: begin
            if (iter_last) begin
               result_d = exec_result;
               zero_d   = (exec_result == '0);
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = IDLE;
            end
         end
      endcase
   end

   // State, flag and result registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         result_q <= '0;
         zero_q   <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Operand latches; only written when a request is accepted in IDLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_q <= OP_FWD;
         a_q   <= '0;
         b_q   <= '0;
      end else if (accept) begin
         sel_q <= alu_op_t'(select);
         a_q   <= data1;
         b_q   <= data2;
      end
   end

   assign result = result_q;
   assign zero   = zero_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=8). Expected result/cycle-count pairs are
// queued when a request is driven and compared when DONE appears.
// Honours MULTICYCLE_ALU_MUL_EN to pick the expected MUL behaviour.
module tb_multicycle_alu;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] select = 3'd0;
   logic [7:0] data1 = 8'h00;
   logic [7:0] data2 = 8'h00;
   logic [7:0] result;
   logic       zero;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] res;
      logic [7:0] cyc;
   } exp_t;

   exp_t sb_q[$];

   multicycle_alu #(
      .WIDTH (8)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .select  (select),
      .data1   (data1),
      .data2   (data2),
      .result  (result),
      .zero    (zero),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   // BUSY and DONE must never overlap.
   always @(negedge clk) begin
      if (reset_n) begin
         checks++;
         assert (!(busy && done)) else begin
            errors++;
            $error("FAIL busy_done_overlap: observed busy=%0b done=%0b required not both",
                   busy, done);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Independent reference of the ALU function and its EXEC cycle count.
   function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] r, output int cyc);
      int amt;
      logic signed [7:0] sb;
      logic signed [7:0] sa;
      r   = 8'h00;
      cyc = 1;
      sb  = b;
      sa  = a;
      case (op)
         3'd0: r = b;
         3'd1: r = a + b;
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: begin
            amt = int'(b) % 8;
            if (amt == 0) r = a;
            else r = (a >> amt) | (a << (8 - amt));
            cyc = (amt == 0) ? 1 : amt;
         end
         3'd5: begin
`ifdef MULTICYCLE_ALU_MUL_EN
            r   = a * b;
            cyc = 8;
`else
            r   = 8'h00;
            cyc = 1;
`endif
         end
         3'd6: begin
            amt = (b >= 8'd8) ? 8 : int'(b);
            r   = sa >>> amt;
            cyc = (amt == 0) ? 1 : amt;
         end
         default: begin
            amt = (sb < 0) ? -int'(sb) : int'(sb);
            if (amt > 8) amt = 8;
            r   = (sb < 0) ? (a >> amt) : (a << amt);
            cyc = (amt == 0) ? 1 : amt;
         end
      endcase
   endfunction

   task automatic push_exp(input logic [7:0] er, input int ec);
      exp_t e;
      e.res = er;
      e.cyc = ec[7:0];
      sb_q.push_back(e);
   endtask

   // Wait (bounded) for DONE, then pop and compare against the scoreboard head.
   task automatic wait_done(input string tag);
      int   n = 0;
      bit   seen = 1'b0;
      exp_t e;
      repeat (40) begin
         @(posedge clk);
         #1;
         n++;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
         if (sb_q.size() != 0) void'(sb_q.pop_front());
      end else if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_cycles"}, 32'(n), 32'(e.cyc));
         chk({tag, "_result"}, {24'd0, result}, {24'd0, e.res});
         chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (e.res == 8'h00)});
      end
   endtask

   task automatic run(input string tag, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] er, input int ec);
      @(negedge clk);
      select = op;
      data1  = a;
      data2  = b;
      start  = 1'b1;
      push_exp(er, ec);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      wait_done(tag);
   endtask

   initial begin
      logic [2:0] rop;
      logic [7:0] ra, rb, rr;
      int         rc;

      // Reset values.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result", {24'd0, result}, 32'h00);
      chk("rst_zero", {31'd0, zero}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Directed vectors.
      run("add_wrap", 3'd1, 8'hFF, 8'h01, 8'h00, 1);
      run("fwd",      3'd0, 8'h12, 8'h34, 8'h34, 1);
      run("and",      3'd2, 8'hF0, 8'h3C, 8'h30, 1);
      run("or",       3'd3, 8'hF0, 8'h0C, 8'hFC, 1);
      run("ror3",     3'd4, 8'h81, 8'h03, 8'h30, 3);
      run("ror8",     3'd4, 8'h81, 8'h08, 8'h81, 1);
      run("ror0",     3'd4, 8'h81, 8'h00, 8'h81, 1);
      run("shl_m2",   3'd7, 8'h81, 8'hFE, 8'h20, 2);
      run("shl_p3",   3'd7, 8'h81, 8'h03, 8'h08, 3);
      run("shl_p8",   3'd7, 8'h81, 8'h08, 8'h00, 8);
      run("shl_m128", 3'd7, 8'h81, 8'h80, 8'h00, 8);
      run("sra9",     3'd6, 8'h80, 8'h09, 8'hFF, 8);
      run("sra2",     3'd6, 8'h40, 8'h02, 8'h10, 2);
`ifdef MULTICYCLE_ALU_MUL_EN
      run("mul",      3'd5, 8'd13, 8'd11, 8'h8F, 8);
`else
      run("mul_off",  3'd5, 8'd13, 8'd11, 8'h00, 1);
`endif

      // Random operations against the reference model.
      for (int i = 0; i < 16; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         model(rop, ra, rb, rr, rc);
         run("rand", rop, ra, rb, rr, rc);
      end

      // START held through a MUL; inputs change mid-operation; next op taken on DONE cycle.
      @(negedge clk);
      select = 3'd5;
      data1  = 8'd13;
      data2  = 8'd11;
      start  = 1'b1;
      model(3'd5, 8'd13, 8'd11, rr, rc);
      push_exp(rr, rc);
      @(posedge clk);
      #1;
      chk("b2b_mul_busy", {31'd0, busy}, 32'd1);
      select = 3'd1;
      data1  = 8'h01;
      data2  = 8'h02;
      push_exp(8'h03, 1);
      wait_done("b2b_mul");
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b_add_busy", {31'd0, busy}, 32'd1);
      wait_done("b2b_add");

      // Asynchronous reset in the middle of a long operation.
      @(negedge clk);
`ifdef MULTICYCLE_ALU_MUL_EN
      select = 3'd5;
      data1  = 8'd13;
      data2  = 8'd11;
`else
      select = 3'd6;
      data1  = 8'h80;
      data2  = 8'h08;
`endif
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_result", {24'd0, result}, 32'h00);
      chk("mid_rst_zero", {31'd0, zero}, 32'd1);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      repeat (8) @(posedge clk);
      #1;
      chk("mid_rst_no_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      select  = 3'd1;
      data1   = 8'h05;
      data2   = 8'h07;
      start   = 1'b1;
      push_exp(8'h0C, 1);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("post_rst_busy", {31'd0, busy}, 32'd1);
      wait_done("post_rst_add");

      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
